shift_ctrl16: RTL
=================

# shift_ctrl16

Multi-cycle shift sequencer for the 16-bit CPU execute stage. Accepts a shift request (op, amount, operand) over a valid/ready handshake, performs it iteratively with a small per-cycle shift step, and returns the result, carry-out and zero flag over a second valid/ready handshake. The ALU uses it in place of a full combinational barrel shifter when area matters more than latency.

## Interface
- WIDTH, 16, operand width; only 16 is supported.
- AMT_W, 4, shift-amount width, log2(WIDTH).

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; high only in IDLE.
- req_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- req_amt  in  AMT_W  shift amount 0..15.
- req_data  in  WIDTH  operand.
- busy  out  1  high in RUN or HOLD.
- rsp_valid  out  1  result available; high only in HOLD.
- rsp_ready  in  1  consumer takes result.
- rsp_data  out  WIDTH  shifted result, registered.
- rsp_carry  out  1  last bit shifted out; 0 if amount is 0.
- rsp_zero  out  1  rsp_data == 0.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: req_ready=1. On req_valid: latch op, data into shift register, cnt=req_amt, carry=0. If req_amt==0, go to HOLD; otherwise go to RUN.
- RUN: each cycle, step = min(cnt, STEP), STEP=1 by default. Shift the register by step per op:
  - SLL: zero fill; carry = last bit out of the MSB.
  - SRL: zero fill; carry = last bit out of the LSB.
  - SRA: fill with the sign bit latched at accept; carry = last bit out of the LSB.
  - ROR: rotate; carry = bit moved from LSB into MSB on the final step.
- RUN: cnt -= step. When cnt becomes 0, go to HOLD.
- HOLD: rsp_valid=1. rsp_data, rsp_carry and rsp_zero are stable. On rsp_ready, go to IDLE.
- Requests arriving while not in IDLE are not accepted; req_ready=0 and inputs are ignored.
- rsp_zero is derived from the registered rsp_data.

## Timing
- Reset values: state IDLE, req_ready 1, busy 0, rsp_valid 0, rsp_data 0, rsp_carry 0, rsp_zero 1, cnt 0.
- Accept occurs at the edge where req_valid and req_ready are both high (edge N).
- Amount 0: HOLD from edge N. rsp_valid is high in the cycle after accept.
- Amount k>0: RUN for ceil(k/STEP) cycles. rsp_valid goes high after edge N+ceil(k/STEP).
- Response completes at the edge where rsp_valid and rsp_ready are both high. req_ready is high in the following cycle; there is no same-cycle turnaround.
- rsp_ready held low: the block stays in HOLD indefinitely with outputs frozen.
- rst asserted in any state: the block goes to IDLE immediately and any in-flight operation is discarded. No rsp_valid is produced for it.
- rsp_ready asserted outside HOLD is ignored.

## Configuration
- SHIFT_CTRL_FAST_EN defined: STEP=4. Each RUN cycle shifts min(cnt,4) bits, so the worst-case RUN length is 4 cycles.
  - Carry is the last bit out of the final multi-bit step.
  - Results are bit-identical to the default build.
- SHIFT_CTRL_FAST_EN undefined: STEP=1, and the worst-case RUN length is 15 cycles.

## Test plan
- SRA 0x8000 by 3 -> rsp_data 0xF000, carry 0, zero 0. rsp_valid after edge N+3, or N+1 with FAST_EN.
- SLL 0xC000 by 1 -> 0x8000, carry 1. SLL 0x0001 by 15 -> 0x8000, carry 0. Latency 15 cycles, or 4 with FAST_EN.
- ROR 0x0001 by 1 -> 0x8000, carry 1. Any op with amt 0 on 0x1234 -> 0x1234, carry 0, rsp_valid in the cycle after accept.
- SRL 0x00F0 by 8 -> 0x0000, zero 1, carry 1 (bit 7 out).
- Backpressure: hold rsp_ready=0 for 5 cycles in HOLD while driving req_valid=1 -> outputs stable, req_ready=0, no extra accept. rsp_ready=1 -> IDLE next cycle, then a new accept.
- Pulse rst for 1 cycle mid-RUN (SLL 0x0001 by 10, after 3 cycles) -> IDLE immediately, rsp_valid never asserts for that request, reset values restored.

Source files
------------

// File: rtl/shift_ctrl16.sv
// shift_ctrl16 -- iterative shift sequencer for the 16-bit execute stage.
//
// Takes one shift request (SLL/SRL/SRA/ROR, amount 0..15, operand) over a
// valid/ready handshake. The shift is done a few bits per cycle. The result,
// carry-out and zero flag come back over a second valid/ready handshake.
//
// Build option: define SHIFT_CTRL_FAST_EN to shift up to 4 bits per RUN
// cycle (STEP=4). By default the block shifts 1 bit per cycle. Both builds
// give the same result and carry.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid/req_ready   request handshake; ready only in IDLE
//   req_op                00 SLL, 01 SRL, 10 SRA, 11 ROR
//   req_amt               shift amount 0..15
//   req_data              operand
//   busy                  high while in RUN or HOLD
//   rsp_valid/rsp_ready   response handshake; valid only in HOLD
//   rsp_data              shifted result (registered)
//   rsp_carry             last bit shifted out, 0 for amount 0
//   rsp_zero              rsp_data == 0
module shift_ctrl16 #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [AMT_W-1:0] req_amt,
    input  logic [WIDTH-1:0] req_data,
    output logic             busy,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_zero
);

`ifdef SHIFT_CTRL_FAST_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   sreg, sreg_nxt;
    logic [AMT_W-1:0]   cnt, step, cnt_nxt;
    logic [1:0]         op;
    logic               carry, carry_nxt;
    logic               sign;
    logic               accept;

    assign accept = (state == IDLE) && req_valid;

    // Bits to shift this cycle: min(cnt, STEP).
    assign step    = (cnt < AMT_W'(STEP)) ? cnt : AMT_W'(STEP);
    assign cnt_nxt = cnt - step;

    // Multi-bit step built as a chain of single-bit steps. Each step
    // overwrites the carry, so the carry that is left is the last bit out.
    always_comb begin
        sreg_nxt  = sreg;
        carry_nxt = carry;
        for (int i = 0; i < STEP; i++) begin
            if (AMT_W'(i) < step) begin
                case (op)
                    OP_SLL: begin
                        carry_nxt = sreg_nxt[WIDTH-1];
                        sreg_nxt  = {sreg_nxt[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        carry_nxt = sreg_nxt[0];
                        sreg_nxt  = {1'b0, sreg_nxt[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        carry_nxt = sreg_nxt[0];
                        sreg_nxt  = {sign, sreg_nxt[WIDTH-1:1]};
                    end
                    default: begin
                        carry_nxt = sreg_nxt[0];
                        sreg_nxt  = {sreg_nxt[0], sreg_nxt[WIDTH-1:1]};
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = (req_amt == '0) ? HOLD : RUN;
            RUN:  if (cnt_nxt == '0) state_nxt = HOLD;
            HOLD: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers. The shift register also holds the result, so
    // rsp_data does not need its own copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg  <= '0;
            cnt   <= '0;
            op    <= OP_SLL;
            carry <= 1'b0;
            sign  <= 1'b0;
        end else if (accept) begin
            sreg  <= req_data;
            cnt   <= req_amt;
            op    <= req_op;
            carry <= 1'b0;
            sign  <= req_data[WIDTH-1];
        end else if (state == RUN) begin
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
            carry <= carry_nxt;
        end
    end

    assign req_ready = (state == IDLE);
    assign busy      = (state == RUN) || (state == HOLD);
    assign rsp_valid = (state == HOLD);
    assign rsp_data  = sreg;
    assign rsp_carry = carry;
    assign rsp_zero  = (sreg == '0);

endmodule
